// File: rtl/cpu_perf_monitor_pkg.sv
// ----------------------------------------------------------------------------
// Package: cpu_perf_pkg
// Purpose: Shared definitions for the CPU performance-counter bank.
//          - Event channel indices, matching the pipeline/cache strobe wiring.
//          - Default counter width.
//          - Freeze-control state encoding.
// ----------------------------------------------------------------------------
package cpu_perf_pkg;

    // Event channel indices (bit positions in the evt strobe vector)
    localparam int EVT_INST   = 0;
    localparam int EVT_IC_REQ = 1;
    localparam int EVT_IC_HIT = 2;
    localparam int EVT_DC_REQ = 3;
    localparam int EVT_DC_HIT = 4;
    localparam int EVT_MEM_RD = 5;
    localparam int EVT_MEM_WR = 6;
    localparam int EVT_REG_WR = 7;

    // Number of channels in the standard CPU hookup
    localparam int DEFAULT_NUM_EVT = EVT_REG_WR + 1;

    // Width of every counter unless overridden
    localparam int DEFAULT_CNT_W = 32;

    // Counting is either running or frozen (by halt or watchdog)
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } freezeState_t;

endpackage

// File: rtl/cpu_perf_monitor_cell.sv
// ----------------------------------------------------------------------------
// Module: perf_counter_cell
// Purpose: One CNT_W-bit event counter with synchronous clear and a sticky
//          overflow flag. With SATURATE != 0 the counter sticks at all-ones;
//          otherwise it wraps to zero. Either way an increment at all-ones
//          sets ovf, which stays set until clr or reset.
// Ports:
//   clk    in   1       clock
//   rst_n  in   1       synchronous active-low reset
//   clr    in   1       synchronous clear of count and ovf (wins over inc)
//   inc    in   1       increment this cycle
//   cnt    out  CNT_W   current count
//   ovf    out  1       sticky overflow flag
// ----------------------------------------------------------------------------
module perf_counter_cell #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic atMax;

    assign atMax = &cnt;

    // Counter and sticky overflow flag; clear beats increment, and at
    // all-ones the increment either holds (saturating) or rolls to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (atMax) begin
                ovf <= 1'b1;
                cnt <= (SATURATE != 0) ? cnt : '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_perf_monitor.sv
// ----------------------------------------------------------------------------
// Module: cpu_perf_monitor
// Purpose: Event-counter bank for the pipelined CPU. Counts cycles plus
//          NUM_EVT per-cycle event strobes, freezes on CPU halt or on a
//          cycle-limit watchdog, and exposes counters through a registered
//          indexed read port (response one cycle after the request).
// Ports:
//   clk           in   1        clock
//   rst_n         in   1        synchronous active-low reset
//   en            in   1        global count enable
//   clr           in   1        clear counters, ovf flags, freeze, watchdog
//   evt           in   NUM_EVT  per-cycle event strobes
//   halt          in   1        CPU halt strobe
//   rd_req        in   1        read request
//   rd_idx        in   IDX_W    channel to read
//   rd_valid      out  1        read response valid
//   rd_data       out  CNT_W    counter value of the channel read
//   rd_ovf        out  1        sticky overflow flag of the channel read
//   cycle_cnt     out  CNT_W    live cycle counter
//   frozen        out  1        counting stopped by halt or watchdog
//   wdog_expired  out  1        sticky watchdog trip flag
// ----------------------------------------------------------------------------
module cpu_perf_monitor
    import cpu_perf_pkg::*;
#(
    parameter int          NUM_EVT    = DEFAULT_NUM_EVT,
    parameter int          CNT_W      = DEFAULT_CNT_W,
    parameter int          SATURATE   = 1,
    parameter int unsigned WDOG_LIMIT = 10000,
    localparam int         IDX_W      = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_ovf,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               frozen,
    output logic               wdog_expired
);

    freezeState_t                    state;
    freezeState_t                    stateNext;
    logic                            active;
    logic                            wdogHit;
    logic                            cycleOvf;
    logic [CNT_W:0]                  cycleNext;
    logic [NUM_EVT-1:0][CNT_W-1:0]   evtCnt;
    logic [NUM_EVT-1:0]              evtOvf;
    logic [CNT_W-1:0]                selCnt;
    logic                            selOvf;

    assign frozen    = (state == ST_FROZEN);
    assign active    = en & ~frozen & ~clr;
    assign cycleNext = {1'b0, cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // The watchdog fires on the active edge that brings the cycle count to
    // the limit. Once the cycle counter has overflowed its value no longer
    // tracks elapsed cycles, so it is not allowed to trip the watchdog.
    assign wdogHit = (WDOG_LIMIT != 0) & active & ~cycleOvf &
                     (64'(cycleNext) == 64'(WDOG_LIMIT));

    // Cycle counter: same clear/saturate/overflow rules as the event channels
    perf_counter_cell #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
    ) uCycleCell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (active),
        .cnt   (cycle_cnt),
        .ovf   (cycleOvf)
    );

    // One counter cell per event strobe
    for (genvar i = 0; i < NUM_EVT; i++) begin : gEvt
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) uEvtCell (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (active & evt[i]),
            .cnt   (evtCnt[i]),
            .ovf   (evtOvf[i])
        );
    end

    // Freeze state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Freeze next-state: a halt or watchdog trip on an active edge freezes
    // from the following cycle (that edge's events still count); only clr
    // or reset resumes counting.
    always_comb begin
        stateNext = state;
        case (state)
            ST_RUN: begin
                if (active && (halt || wdogHit)) begin
                    stateNext = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (clr) begin
                    stateNext = ST_RUN;
                end
            end
            default: begin
                stateNext = ST_RUN;
            end
        endcase
    end

    // Sticky watchdog flag, dropped only by clr or reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_expired <= 1'b0;
        end else if (clr) begin
            wdog_expired <= 1'b0;
        end else if (wdogHit) begin
            wdog_expired <= 1'b1;
        end
    end

    // Read mux: an index with no matching channel selects zero
    always_comb begin
        selCnt = '0;
        selOvf = 1'b0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                selCnt = evtCnt[i];
                selOvf = evtOvf[i];
            end
        end
    end

    // Read response register: captures the channel state as it stands before
    // this edge's update. Counters are hidden (read as zero) while en is low.
    // Without a request the data and flag hold their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= en ? selCnt : '0;
                rd_ovf  <= en & selOvf;
            end
        end
    end

endmodule
